// File: rtl/i2c_peripheral_if.sv
// Pin and register-file signals of the I2C target, bundled for a single port.
// The slave view belongs to the peripheral; the master view belongs to whatever drives the pins and serves registers.
interface i2c_peripheral_if;
    logic        scl_in;
    logic        sda_in;
    logic        sda_oe;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata;
    logic        busy;

    modport slave (
        input  scl_in, sda_in, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

    modport master (
        output scl_in, sda_in, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );
endinterface

// File: rtl/i2c_peripheral.sv
// I2C target for the two-byte register protocol: oversampled, glitch-filtered SCL/SDA,
// open-drain SDA drive and a 16-bit register-file port.
module i2c_peripheral #(
    parameter logic [6:0]  PERIPHERAL_ADDRESS = 7'h50,
    parameter int unsigned FILTER_LEN         = 3
) (
    input  logic            clk,
    input  logic            rst,
    i2c_peripheral_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    state_t                state, state_next;
    logic [1:0]            scl_sync, sda_sync;
    logic [FILTER_LEN-1:0] scl_hist, sda_hist;
    logic                  scl_f, sda_f, scl_prev, sda_prev;
    logic                  scl_rise, scl_fall, start_cond, stop_cond;

    logic [3:0]  bit_cnt, bit_cnt_next;
    logic [7:0]  shift, shift_next;
    logic [1:0]  byte_idx, byte_idx_next;
    logic [7:0]  byte_one, byte_one_next;
    logic [15:0] rd_shift, rd_shift_next;
    logic        rd_load;
    logic        sda_oe, sda_oe_next;
    logic        busy, busy_next;
    logic        reg_we, reg_we_next;
    logic        reg_re, reg_re_next;
    logic [7:0]  reg_addr, reg_addr_next;
    logic [15:0] reg_wdata, reg_wdata_next;

    // A filtered level only moves once FILTER_LEN consecutive synced samples agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
            scl_sync <= {scl_sync[0], bus.scl_in};
            sda_sync <= {sda_sync[0], bus.sda_in};
            scl_hist <= (scl_hist << 1) | FILTER_LEN'(scl_sync[1]);
            sda_hist <= (sda_hist << 1) | FILTER_LEN'(sda_sync[1]);
            if (&scl_hist)       scl_f <= 1'b1;
            else if (~|scl_hist) scl_f <= 1'b0;
            if (&sda_hist)       sda_f <= 1'b1;
            else if (~|sda_hist) sda_f <= 1'b0;
            scl_prev <= scl_f;
            sda_prev <= sda_f;
        end
    end

    assign scl_rise   = scl_f & ~scl_prev;
    assign scl_fall   = ~scl_f & scl_prev;
    assign start_cond = scl_f & scl_prev & sda_prev & ~sda_f;
    assign stop_cond  = scl_f & scl_prev & ~sda_prev & sda_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            byte_idx  <= '0;
            byte_one  <= '0;
            rd_shift  <= '0;
            rd_load   <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shift     <= shift_next;
            byte_idx  <= byte_idx_next;
            byte_one  <= byte_one_next;
            rd_shift  <= rd_shift_next;
            rd_load   <= reg_re;
            sda_oe    <= sda_oe_next;
            busy      <= busy_next;
            reg_we    <= reg_we_next;
            reg_re    <= reg_re_next;
            reg_addr  <= reg_addr_next;
            reg_wdata <= reg_wdata_next;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first, so no path through this block infers a latch.
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        shift_next     = shift;
        byte_idx_next  = byte_idx;
        byte_one_next  = byte_one;
        rd_shift_next  = rd_load ? bus.reg_rdata : rd_shift;
        sda_oe_next    = sda_oe;
        busy_next      = busy;
        reg_we_next    = 1'b0;
        reg_re_next    = 1'b0;
        reg_addr_next  = reg_addr;
        reg_wdata_next = reg_wdata;

        if (scl_rise && bit_cnt < 4'd8 && (state inside {ADDR, REG, WR_BYTE, RD_BYTE})) begin
            shift_next   = {shift[6:0], sda_f};
            bit_cnt_next = bit_cnt + 4'd1;
        end

        case (state)
            ADDR: if (scl_fall && bit_cnt == 4'd8) begin
                if (shift[7:1] == PERIPHERAL_ADDRESS) begin
                    sda_oe_next = 1'b1;
                    busy_next   = 1'b1;
                    state_next  = ADDR_ACK;
                end else begin
                    busy_next  = 1'b0;
                    state_next = IGNORE;
                end
            end
            ADDR_ACK: begin
                // Reads leave at the ACK rise so the register file has half a bit to answer.
                if (scl_rise && shift[0]) begin
                    reg_re_next   = 1'b1;
                    bit_cnt_next  = '0;
                    byte_idx_next = '0;
                    state_next    = RD_BYTE;
                end else if (scl_fall && !shift[0]) begin
                    sda_oe_next  = 1'b0;
                    bit_cnt_next = '0;
                    state_next   = REG;
                end
            end
            REG: if (scl_fall && bit_cnt == 4'd8) begin
                reg_addr_next = shift;
                sda_oe_next   = 1'b1;
                state_next    = REG_ACK;
            end
            REG_ACK: if (scl_fall) begin
                sda_oe_next   = 1'b0;
                bit_cnt_next  = '0;
                byte_idx_next = '0;
                state_next    = WR_BYTE;
            end
            WR_BYTE: if (scl_fall && bit_cnt == 4'd8) begin
                if (byte_idx == 2'd0) byte_one_next = shift;
                sda_oe_next = (byte_idx < 2'd2);
                state_next  = WR_ACK;
            end
            WR_ACK: if (scl_fall) begin
                sda_oe_next = 1'b0;
                if (byte_idx == 2'd1) begin
                    reg_wdata_next = {byte_one, shift};
                    reg_we_next    = 1'b1;
                end
                if (byte_idx != 2'd2) byte_idx_next = byte_idx + 2'd1;
                bit_cnt_next = '0;
                state_next   = WR_BYTE;
            end
            RD_BYTE: if (scl_fall) begin
                if (bit_cnt == 4'd0) begin
                    sda_oe_next = ~rd_shift[15];
                end else if (bit_cnt < 4'd8) begin
                    rd_shift_next = {rd_shift[14:0], 1'b0};
                    sda_oe_next   = ~rd_shift[14];
                end else begin
                    rd_shift_next = {rd_shift[14:0], 1'b0};
                    sda_oe_next   = 1'b0;
                    state_next    = RD_ACK;
                end
            end
            RD_ACK: if (scl_rise) begin
                if (!sda_f && byte_idx == 2'd0) begin
                    byte_idx_next = 2'd1;
                    bit_cnt_next  = '0;
                    state_next    = RD_BYTE;
                end else begin
                    state_next = IGNORE;
                end
            end
            IGNORE:  sda_oe_next = 1'b0;
            default: ;
        endcase

        // Bus conditions win over whatever the byte-level logic decided this cycle.
        if (stop_cond) begin
            state_next    = IDLE;
            sda_oe_next   = 1'b0;
            busy_next     = 1'b0;
            bit_cnt_next  = '0;
            byte_idx_next = '0;
        end else if (start_cond) begin
            state_next    = ADDR;
            sda_oe_next   = 1'b0;
            bit_cnt_next  = '0;
            byte_idx_next = '0;
        end
    end

    assign bus.sda_oe    = sda_oe;
    assign bus.busy      = busy;
    assign bus.reg_we    = reg_we;
    assign bus.reg_re    = reg_re;
    assign bus.reg_addr  = reg_addr;
    assign bus.reg_wdata = reg_wdata;

endmodule

// File: tb/tb_i2c_peripheral.sv
// Bench for i2c_peripheral: an I2C controller model drives randomized and directed transactions,
// a register-file model serves reads, and a scoreboard checks every write/read strobe.
module tb_i2c_peripheral;

    localparam int Q = 12;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_peripheral_if bus ();

    i2c_peripheral #(.PERIPHERAL_ADDRESS(7'h50), .FILTER_LEN(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic glitch_en = 1'b0;
    assign bus.scl_in = m_scl;
    assign bus.sda_in = m_sda & ~bus.sda_oe;

    logic [15:0] rf      [256];
    logic [15:0] ref_mem [256];
    logic [7:0]  ref_ptr = 8'h00;

    always @(posedge clk) begin
        if (bus.reg_we) rf[bus.reg_addr] <= bus.reg_wdata;
        if (bus.reg_re) bus.reg_rdata <= rf[bus.reg_addr];
    end

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    wr_t        mon_wr;
    logic [7:0] mon_rd;
    int total = 0;
    int bad   = 0;
    logic watch_quiet = 1'b0;
    int quiet_oe = 0;
    int quiet_busy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.reg_we && bus.reg_re) check("we_re_overlap", 32'(bus.reg_we & bus.reg_re), 0);
            if (bus.reg_we) begin
                check("we_expected", {31'b0, exp_wr.size() != 0}, 1);
                if (exp_wr.size() != 0) begin
                    mon_wr = exp_wr.pop_front();
                    check("we_addr", 32'(bus.reg_addr), 32'(mon_wr.addr));
                    check("we_data", 32'(bus.reg_wdata), 32'(mon_wr.data));
                end
            end
            if (bus.reg_re) begin
                check("re_expected", {31'b0, exp_rd.size() != 0}, 1);
                if (exp_rd.size() != 0) begin
                    mon_rd = exp_rd.pop_front();
                    check("re_addr", 32'(bus.reg_addr), 32'(mon_rd));
                end
            end
            if (watch_quiet && bus.sda_oe) quiet_oe++;
            if (watch_quiet && bus.busy) quiet_busy++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;
        if (glitch_en) begin
            tick(Q / 2); m_scl = 1'b1; tick(1); m_scl = 1'b0; tick(Q - Q / 2 - 1);
            m_scl = 1'b1;
            tick(Q / 2); m_scl = 1'b0; tick(1); m_scl = 1'b1; tick(Q - Q / 2 - 1);
        end else begin
            tick(Q); m_scl = 1'b1; tick(Q);
        end
        m_scl = 1'b0;
        tick(2);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1;
        tick(Q); m_scl = 1'b1;
        tick(Q / 2); b = bus.sda_in;
        tick(Q - Q / 2); m_scl = 1'b0;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack_bit);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
        send_bit(ack_bit);
    endtask

    task automatic start_c();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(2);
    endtask

    task automatic stop_c();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic do_write(input logic [7:0] reg_a, input int n,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic ack;
        logic [7:0] d;
        wr_t e;
        start_c();
        send_byte(8'hA0, ack);
        check("wr_addr_ack", 32'(ack), 0);
        check("busy_after_match", 32'(bus.busy), 1);
        send_byte(reg_a, ack);
        check("wr_reg_ack", 32'(ack), 0);
        ref_ptr = reg_a;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? b0 : (i == 1) ? b1 : b2;
            if (i == 1) begin
                e.addr = reg_a;
                e.data = {b0, b1};
                exp_wr.push_back(e);
                ref_mem[reg_a] = {b0, b1};
            end
            send_byte(d, ack);
            check("wr_data_ack", 32'(ack), (i < 2) ? 0 : 1);
        end
        stop_c();
        check("busy_after_stop", 32'(bus.busy), 0);
        check("reg_addr_after_wr", 32'(bus.reg_addr), 32'(ref_ptr));
    endtask

    task automatic do_read(input int nbytes, input logic set_ptr, input logic [7:0] ptr);
        logic ack;
        logic [7:0] d;
        logic [15:0] word;
        if (set_ptr) do_write(ptr, 0, 8'h00, 8'h00, 8'h00);
        word = ref_mem[ref_ptr];
        start_c();
        exp_rd.push_back(ref_ptr);
        send_byte(8'hA1, ack);
        check("rd_addr_ack", 32'(ack), 0);
        for (int i = 0; i < nbytes; i++) begin
            recv_byte(d, (i == nbytes - 1) ? 1'b1 : 1'b0);
            check("rd_byte", 32'(d), (i == 0) ? 32'(word[15:8]) : 32'(word[7:0]));
        end
        stop_c();
        check("rd_busy_after_stop", 32'(bus.busy), 0);
        check("reg_addr_after_rd", 32'(bus.reg_addr), 32'(ref_ptr));
    endtask

    initial begin
        logic ack;
        logic [15:0] v;
        int k;

        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            rf[i] = v;
            ref_mem[i] = v;
        end
        rf[8'h34] = 16'hCAFE;
        ref_mem[8'h34] = 16'hCAFE;

        tick(6);
        check("rst_sda_oe", 32'(bus.sda_oe), 0);
        check("rst_reg_addr", 32'(bus.reg_addr), 0);
        check("rst_reg_wdata", 32'(bus.reg_wdata), 0);
        check("rst_reg_we", 32'(bus.reg_we), 0);
        check("rst_reg_re", 32'(bus.reg_re), 0);
        check("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        tick(10);

        // Plain two-byte write, then pointer write / STOP / read.
        do_write(8'h12, 2, 8'hBE, 8'hEF, 8'h00);
        check("wdata_beef", 32'(bus.reg_wdata), 32'h0000BEEF);
        do_read(2, 1'b1, 8'h34);

        // Foreign address: target must stay silent and idle.
        start_c();
        watch_quiet = 1'b1;
        send_byte(8'hA2, ack);
        check("foreign_addr_nack", 32'(ack), 1);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'($urandom), ack);
            check("foreign_byte_nack", 32'(ack), 1);
        end
        stop_c();
        watch_quiet = 1'b0;
        check("foreign_sda_oe_cycles", 32'(quiet_oe), 0);
        check("foreign_busy_cycles", 32'(quiet_busy), 0);

        // Third data byte is refused and discarded.
        do_write(8'h40, 3, 8'hBE, 8'hEF, 8'h55);
        check("wdata_after_third", 32'(bus.reg_wdata), 32'h0000BEEF);

        // Repeated START after one data byte: no write may follow.
        start_c();
        send_byte(8'hA0, ack);
        check("rs_addr_ack", 32'(ack), 0);
        send_byte(8'h77, ack);
        check("rs_reg_ack", 32'(ack), 0);
        ref_ptr = 8'h77;
        send_byte(8'h11, ack);
        check("rs_data_ack", 32'(ack), 0);
        start_c();
        stop_c();
        check("rs_reg_addr", 32'(bus.reg_addr), 32'h77);
        check("rs_busy", 32'(bus.busy), 0);

        // Reset while the target is driving read data.
        do_write(8'h56, 2, 8'h12, 8'h34, 8'h00);
        do_write(8'h56, 0, 8'h00, 8'h00, 8'h00);
        start_c();
        exp_rd.push_back(8'h56);
        send_byte(8'hA1, ack);
        check("mr_addr_ack", 32'(ack), 0);
        k = 0;
        while (!bus.sda_oe && k < 40) begin
            tick(1);
            k++;
        end
        check("mr_driving", 32'(bus.sda_oe), 1);
        rst = 1'b1;
        tick(1);
        check("mr_sda_oe_released", 32'(bus.sda_oe), 0);
        check("mr_busy", 32'(bus.busy), 0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(5);
        rst = 1'b0;
        ref_ptr = 8'h00;
        tick(10);
        check("mr_reg_addr", 32'(bus.reg_addr), 0);

        // SCL glitches during the write must not add bits.
        glitch_en = 1'b1;
        do_write(8'h21, 2, 8'hBE, 8'hEF, 8'h00);
        glitch_en = 1'b0;
        check("glitch_wdata", 32'(bus.reg_wdata), 32'h0000BEEF);
        do_read(2, 1'b1, 8'h21);

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(8'($urandom), int'($urandom_range(0, 3)),
                         8'($urandom), 8'($urandom), 8'($urandom));
            else
                do_read(int'($urandom_range(1, 2)), $urandom_range(0, 3) != 0, 8'($urandom));
        end

        tick(20);
        check("pending_writes", 32'(exp_wr.size()), 0);
        check("pending_reads", 32'(exp_rd.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
